// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED PIO pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_PERIOD = 2'd1;
  localparam logic [1:0] CSR_SEED   = 2'd2;
  localparam logic [1:0] CSR_STATUS = 2'd3;

  function automatic logic [7:0] start_pattern(input mode_e m, input logic [7:0] seed);
    case (m)
      MODE_COUNT:  return 8'h00;
      MODE_BOUNCE: return 8'h01;
      default:     return seed;
    endcase
  endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Loadable down-counter prescaler; tick is high for one cycle when the count hits zero.
module led_seq_tick #(
  parameter int PRESCALE_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reload,
  input  logic                  hold,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // A reload or hold preempts the zero crossing, so no tick escapes in that cycle.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q - PRESCALE_W'(1);
    if (hold || reload) begin
      cnt_d = period;
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = period;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pio_sequencer.sv
// Autonomous LED pattern engine: CSR slave for configuration, Avalon-MM master
// issuing single-cycle writes to the LED PIO data register.
module led_pio_sequencer
  import led_seq_pkg::*;
#(
  parameter int PRESCALE_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  csr_address,
  input  logic        csr_chipselect,
  input  logic        csr_write_n,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  logic                  csr_wr, ctrl_wr, period_wr, seed_wr;
  mode_e                 wr_mode;
  logic                  en_q, en_d;
  mode_e                 mode_q, mode_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [7:0]            seed_q, seed_d;
  logic [7:0]            pattern_q, pattern_d;
  logic                  dir_q, dir_d;
  state_e                state_q, state_d;
  logic                  pio_cs_q, pio_cs_d;
  logic [7:0]            pio_data_q, pio_data_d;
  logic [7:0]            step_pat;
  logic                  step_dir;
  logic                  tick, hold, reload;

  assign csr_wr    = csr_chipselect && !csr_write_n;
  assign ctrl_wr   = csr_wr && (csr_address == CSR_CTRL);
  assign period_wr = csr_wr && (csr_address == CSR_PERIOD);
  assign seed_wr   = csr_wr && (csr_address == CSR_SEED);
  assign wr_mode   = mode_e'(csr_writedata[2:1]);

  assign hold   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign reload = ctrl_wr || seed_wr;

  led_seq_tick #(.PRESCALE_W(PRESCALE_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .reload  (reload),
    .hold    (hold),
    .period  (period_q),
    .tick    (tick)
  );

  // Next pattern for the current mode; bounce flips direction on reaching an end.
  always_comb begin
    step_pat = pattern_q;
    step_dir = dir_q;
    case (mode_q)
      MODE_COUNT:  step_pat = pattern_q + 8'd1;
      MODE_BOUNCE: begin
        step_pat = dir_q ? {pattern_q[6:0], 1'b0} : {1'b0, pattern_q[7:1]};
        if (dir_q && step_pat == 8'h80)       step_dir = 1'b0;
        else if (!dir_q && step_pat == 8'h01) step_dir = 1'b1;
      end
      MODE_BLINK:  step_pat = (pattern_q != 8'h00) ? 8'h00 : seed_q;
      default:     step_pat = pattern_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    en_d      = en_q;
    mode_d    = mode_q;
    period_d  = period_q;
    seed_d    = seed_q;
    if (ctrl_wr) begin
      en_d   = csr_writedata[0];
      mode_d = wr_mode;
    end
    if (period_wr) period_d = csr_writedata[PRESCALE_W-1:0];
    if (seed_wr)   seed_d   = csr_writedata[7:0];

    case (state_q)
      ST_IDLE: if (ctrl_wr && csr_writedata[0]) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d   = ST_WRITE;
        pattern_d = start_pattern(mode_q, seed_q);
        if (mode_q == MODE_BOUNCE) dir_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        if (seed_wr && mode_q == MODE_MANUAL) begin
          pattern_d = csr_writedata[7:0];
          state_d   = ST_WRITE;
        end else if (tick && state_q == ST_RUN && mode_q != MODE_MANUAL) begin
          pattern_d = step_pat;
          dir_d     = step_dir;
          state_d   = ST_WRITE;
        end
      end
    endcase

    // CTRL writes override whatever the running state decided.
    if (ctrl_wr && state_q != ST_IDLE) begin
      if (!csr_writedata[0]) begin
        state_d   = ST_IDLE;
        pattern_d = pattern_q;
        dir_d     = dir_q;
      end else if (wr_mode != mode_q) begin
        state_d = ST_LOAD;
      end
    end

    pio_cs_d   = (state_d == ST_WRITE);
    pio_data_d = pio_cs_d ? pattern_d : pio_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      mode_q     <= MODE_MANUAL;
      period_q   <= '0;
      seed_q     <= 8'h00;
      pattern_q  <= 8'h00;
      dir_q      <= 1'b1;
      pio_cs_q   <= 1'b0;
      pio_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      period_q   <= period_d;
      seed_q     <= seed_d;
      pattern_q  <= pattern_d;
      dir_q      <= dir_d;
      pio_cs_q   <= pio_cs_d;
      pio_data_q <= pio_data_d;
    end
  end

  always_comb begin
    csr_readdata = 32'd0;
    case (csr_address)
      CSR_CTRL:   csr_readdata = {29'd0, mode_q, en_q};
      CSR_PERIOD: csr_readdata[PRESCALE_W-1:0] = period_q;
      CSR_SEED:   csr_readdata = {24'd0, seed_q};
      default:    csr_readdata = {22'd0, (state_q != ST_IDLE), dir_q, pattern_q};
    endcase
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = pio_cs_q;
  assign pio_write_n    = !pio_cs_q;
  assign pio_writedata  = {24'd0, pio_data_q};

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Directed self-checking bench for led_pio_sequencer: logs every PIO write and
// compares data and cycle stamps against hand-derived sequences.
module tb_led_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  csr_address = 2'd0;
  logic        csr_chipselect = 1'b0;
  logic        csr_write_n = 1'b1;
  logic [31:0] csr_writedata = 32'd0;
  logic [31:0] csr_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int proto_err = 0;
  logic [7:0] log_d[$];
  int         log_c[$];

  led_pio_sequencer #(.PRESCALE_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .csr_address    (csr_address),
    .csr_chipselect (csr_chipselect),
    .csr_write_n    (csr_write_n),
    .csr_writedata  (csr_writedata),
    .csr_readdata   (csr_readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pio_chipselect === 1'b1) begin
      log_d.push_back(pio_writedata[7:0]);
      log_c.push_back(cyc);
    end
    if (pio_write_n !== ~pio_chipselect || pio_address !== 2'b00 ||
        pio_writedata[31:8] !== 24'd0)
      proto_err <= proto_err + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d, output int c);
    csr_address    = a;
    csr_writedata  = d;
    csr_chipselect = 1'b1;
    csr_write_n    = 1'b0;
    c              = cyc;
    @(negedge clk);
    csr_chipselect = 1'b0;
    csr_write_n    = 1'b1;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address    = a;
    csr_chipselect = 1'b1;
    #1;
    d              = csr_readdata;
    csr_chipselect = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int i = 0;
    while (log_d.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic clear_log();
    log_d.delete();
    log_c.delete();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'd0 ||
        pio_address !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs: cs=%b wn=%b wd=%h addr=%h required cs=0 wn=1 wd=0 addr=0",
               pio_chipselect, pio_write_n, pio_writedata, pio_address);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      csr_rd(a[1:0], rd);
      exp = (a == 3) ? 32'h100 : 32'h0;
      total++;
      if (rd !== exp) begin
        bad++;
        $display("FAIL reset_csr%0d: got %h required %h", a, rd, exp);
      end
    end
    clear_log();
    repeat (10) @(negedge clk);
    total++;
    if (log_d.size() != 0) begin
      bad++;
      $display("FAIL reset_no_strobe: got %0d writes required 0", log_d.size());
    end
  endtask

  task automatic test_count();
    int c, k;
    logic [7:0] e;
    clear_log();
    csr_wr(2'd1, 32'd3, c);
    csr_wr(2'd0, 32'h3, k);
    wait_log(258, 1200);
    total++;
    if (log_d.size() < 258) begin
      bad++;
      $display("FAIL count_len: got %0d writes required 258", log_d.size());
    end else begin
      for (int i = 0; i < 258; i++) begin
        e = i[7:0];
        total++;
        if (log_d[i] !== e) begin
          bad++;
          $display("FAIL count_data[%0d]: got %h required %h", i, log_d[i], e);
        end
        total++;
        if (log_c[i] != k + 2 + 4 * i) begin
          bad++;
          $display("FAIL count_time[%0d]: got cycle %0d required %0d", i, log_c[i], k + 2 + 4 * i);
        end
      end
    end
  endtask

  task automatic test_disable();
    int c;
    logic [7:0] last;
    logic [31:0] s0, s1;
    csr_wr(2'd0, 32'h2, c);
    last = (log_d.size() > 0) ? log_d[log_d.size() - 1] : 8'h00;
    clear_log();
    csr_rd(2'd3, s0);
    total++;
    if (s0 !== {22'd0, 1'b0, 1'b1, last}) begin
      bad++;
      $display("FAIL disable_status: got %h required %h", s0, {22'd0, 1'b0, 1'b1, last});
    end
    repeat (20) @(negedge clk);
    total++;
    if (log_d.size() != 0) begin
      bad++;
      $display("FAIL disable_no_strobe: got %0d writes required 0", log_d.size());
    end
    csr_rd(2'd3, s1);
    total++;
    if (s1 !== s0) begin
      bad++;
      $display("FAIL disable_frozen: got %h required %h", s1, s0);
    end
  endtask

  task automatic test_bounce();
    int c, k;
    logic [7:0] exp_seq[17] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    clear_log();
    csr_wr(2'd1, 32'd0, c);
    csr_wr(2'd0, 32'h5, k);
    wait_log(17, 100);
    total++;
    if (log_d.size() < 17) begin
      bad++;
      $display("FAIL bounce_len: got %0d writes required 17", log_d.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        total++;
        if (log_d[i] !== exp_seq[i] || log_c[i] != k + 2 + 2 * i) begin
          bad++;
          $display("FAIL bounce[%0d]: got %h at %0d required %h at %0d",
                   i, log_d[i], log_c[i], exp_seq[i], k + 2 + 2 * i);
        end
      end
    end
    csr_wr(2'd0, 32'h4, c);
  endtask

  task automatic test_blink();
    int c, k, nz;
    logic [7:0] exp_seq[4] = '{8'hA5, 8'h00, 8'hA5, 8'h00};
    clear_log();
    csr_wr(2'd2, 32'hA5, c);
    csr_wr(2'd1, 32'd1, c);
    csr_wr(2'd0, 32'h7, k);
    wait_log(4, 100);
    total++;
    if (log_d.size() < 4) begin
      bad++;
      $display("FAIL blink_len: got %0d writes required 4", log_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (log_d[i] !== exp_seq[i] || log_c[i] != k + 2 + 2 * i) begin
          bad++;
          $display("FAIL blink[%0d]: got %h at %0d required %h at %0d",
                   i, log_d[i], log_c[i], exp_seq[i], k + 2 + 2 * i);
        end
      end
    end
    csr_wr(2'd2, 32'h3C, c);
    clear_log();
    wait_log(4, 100);
    nz = 0;
    total++;
    if (log_d.size() < 4) begin
      bad++;
      $display("FAIL blink_reseed_len: got %0d writes required 4", log_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (log_d[i] != 8'h00) nz++;
        total++;
        if (log_d[i] !== 8'h00 && log_d[i] !== 8'h3C) begin
          bad++;
          $display("FAIL blink_reseed[%0d]: got %h required 3c or 00", i, log_d[i]);
        end
      end
      total++;
      if (nz != 2) begin
        bad++;
        $display("FAIL blink_alternate: got %0d nonzero of 4 required 2", nz);
      end
    end
    csr_wr(2'd0, 32'h6, c);
  endtask

  task automatic test_manual();
    int c, k;
    logic [7:0] seeds[2] = '{8'h5A, 8'hC3};
    logic [31:0] s;
    clear_log();
    csr_wr(2'd2, 32'h11, c);
    csr_wr(2'd1, 32'd0, c);
    csr_wr(2'd0, 32'h1, k);
    repeat (12) @(negedge clk);
    total++;
    if (log_d.size() != 1 || log_d[0] !== 8'h11 || log_c[0] != k + 2) begin
      bad++;
      $display("FAIL manual_load: got %0d writes first %h at %0d required 1 write 11 at %0d",
               log_d.size(), (log_d.size() > 0) ? log_d[0] : 8'h00,
               (log_c.size() > 0) ? log_c[0] : -1, k + 2);
    end
    for (int j = 0; j < 2; j++) begin
      clear_log();
      csr_wr(2'd2, {24'd0, seeds[j]}, c);
      repeat (10) @(negedge clk);
      total++;
      if (log_d.size() != 1 || log_d[0] !== seeds[j] || log_c[0] != c + 1) begin
        bad++;
        $display("FAIL manual_seed%0d: got %0d writes first %h at %0d required 1 write %h at %0d",
                 j, log_d.size(), (log_d.size() > 0) ? log_d[0] : 8'h00,
                 (log_c.size() > 0) ? log_c[0] : -1, seeds[j], c + 1);
      end
    end
    csr_rd(2'd3, s);
    total++;
    if (s[9:0] !== {1'b1, 1'b1, 8'hC3}) begin
      bad++;
      $display("FAIL manual_status: got %h required %h", s[9:0], {1'b1, 1'b1, 8'hC3});
    end
    csr_wr(2'd0, 32'h0, c);
  endtask

  task automatic test_ctrl_tick();
    int c, k, n;
    logic [7:0] exp_d[3] = '{8'h00, 8'h01, 8'h02};
    int exp_c[3];
    clear_log();
    csr_wr(2'd1, 32'd3, c);
    csr_wr(2'd0, 32'h3, k);
    n = 0;
    while (cyc != k + 9 && n < 50) begin
      @(negedge clk);
      n++;
    end
    csr_wr(2'd0, 32'h3, c);
    exp_c = '{k + 2, k + 6, k + 14};
    wait_log(3, 40);
    total++;
    if (log_d.size() < 3) begin
      bad++;
      $display("FAIL ctrl_tick_len: got %0d writes required 3", log_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (log_d[i] !== exp_d[i] || log_c[i] != exp_c[i]) begin
          bad++;
          $display("FAIL ctrl_tick[%0d]: got %h at %0d required %h at %0d",
                   i, log_d[i], log_c[i], exp_d[i], exp_c[i]);
        end
      end
    end
    csr_wr(2'd0, 32'h2, c);
  endtask

  task automatic test_reset_mid_write();
    int c, k, n;
    logic [31:0] rd;
    clear_log();
    csr_wr(2'd1, 32'd3, c);
    csr_wr(2'd0, 32'h3, k);
    n = 0;
    while (cyc != k + 6 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h1) begin
      bad++;
      $display("FAIL midwrite_pre: got cs=%b wd=%h required cs=1 wd=00000001",
               pio_chipselect, pio_writedata);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'd0) begin
      bad++;
      $display("FAIL midwrite_drop: got cs=%b wn=%b wd=%h required cs=0 wn=1 wd=0",
               pio_chipselect, pio_write_n, pio_writedata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    csr_rd(2'd3, rd);
    total++;
    if (rd !== 32'h100) begin
      bad++;
      $display("FAIL midwrite_status: got %h required 00000100", rd);
    end
    csr_rd(2'd0, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL midwrite_ctrl: got %h required 00000000", rd);
    end
    clear_log();
    repeat (10) @(negedge clk);
    total++;
    if (log_d.size() != 0) begin
      bad++;
      $display("FAIL midwrite_quiet: got %0d writes required 0", log_d.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count();
    test_disable();
    test_bounce();
    test_blink();
    test_manual();
    test_ctrl_tick();
    test_reset_mid_write();
    total++;
    if (proto_err != 0) begin
      bad++;
      $display("FAIL pio_protocol: got %0d bad cycles required 0", proto_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
